pixel_burst_packer: RTL

- Parametrised successor to the single-lane write-side FIFO controller.
- Takes multi-lane RAW pixel beats from the sensor/MIPI path, extracts the upper bits of each lane, and packs them into DDR-width words in an internal synchronous FIFO.
- Raises a burst trigger for the DDR write arbiter.
- Adds frame-end flush with zero pad, frame-start resync, and a sticky overflow flag.

---
 rtl/pixel_pack_pkg.sv | 42 ++++
 rtl/pp_sync_fifo.sv | 73 +++++++
 rtl/pixel_burst_packer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pixel_pack_pkg.sv
// Shared sizing helpers and defaults for the pixel burst packer.
// Latency: none (package only).
// Backpressure: none (package only).
package pixel_pack_pkg;

    localparam int LANES_DEF     = 4;
    localparam int PIX_IN_W_DEF  = 10;
    localparam int PIX_OUT_W_DEF = 8;
    localparam int OUT_W_DEF     = 128;
    localparam int DEPTH_DEF     = 32;
    localparam int BURST_LEN_DEF = 16;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bits contributed by one input beat after extraction (and duplication).
    function automatic int beat_bits(input int lanes, input int pix_out_w, input bit dup);
        return lanes * pix_out_w * (dup ? 2 : 1);
    endfunction

    // Number of beats that fill one packed output word.
    function automatic int beats_per_word(input int lanes, input int pix_out_w,
                                          input int out_w, input bit dup);
        return out_w / beat_bits(lanes, pix_out_w, dup);
    endfunction

    // True when the packed word is an exact multiple of the beat width.
    function automatic bit word_divides(input int lanes, input int pix_out_w,
                                        input int out_w, input bit dup);
        return (out_w % beat_bits(lanes, pix_out_w, dup)) == 0;
    endfunction

endpackage

// File: rtl/pp_sync_fifo.sv
// Single-clock word FIFO with registered read data, occupancy count and full/empty flags.
// Latency: write visible in count the cycle after wr_en; rd_data valid the cycle after a pop.
// Backpressure: a write while full is accepted only with a same-cycle pop, otherwise drop is raised.
module pp_sync_fifo
    import pixel_pack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = OUT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [clog2(DEPTH):0]     count,
    output logic                      drop
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = rd_data_q;

    // A pop frees a slot in the same cycle, so full+pop still takes the write.
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | rd_en);
    assign drop    = wr_en & full & ~rd_en;

    // Storage array: no reset needed, contents are qualified by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_burst_packer.sv
// Packs the MSBs of multi-lane pixel beats into wide words and queues them for the DDR writer.
// Latency: last beat to data_count increment is 2 cycles; rd_data valid 1 cycle after rd_en.
// Backpressure: none upstream; words pushed while the FIFO is full are dropped and ovf is set.
// Build option PACK_DUP_EN duplicates every extracted byte ({b,b}) for the 16-bit display path.
module pixel_burst_packer
    import pixel_pack_pkg::*;
#(
    parameter int LANES     = LANES_DEF,
    parameter int PIX_IN_W  = PIX_IN_W_DEF,
    parameter int PIX_OUT_W = PIX_OUT_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic                        sclk,
    input  logic                        s_rst,
    input  logic                        frame_start,
    input  logic                        frame_end,
    input  logic [LANES*PIX_IN_W-1:0]   pix_data,
    input  logic                        pix_vld,
    input  logic                        rd_en,
    output logic [OUT_W-1:0]            rd_data,
    output logic                        empty,
    output logic                        full,
    output logic [clog2(DEPTH):0]       data_count,
    output logic                        wr_trig,
    output logic                        ovf,
    input  logic                        ovf_clr
);

`ifdef PACK_DUP_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    localparam int LB    = PIX_OUT_W * (DUP ? 2 : 1);
    localparam int BB    = beat_bits(LANES, PIX_OUT_W, DUP);
    localparam int BEATS = beats_per_word(LANES, PIX_OUT_W, OUT_W, DUP);
    localparam int BCW   = clog2(BEATS + 1);
    localparam int CW    = clog2(DEPTH) + 1;

    if (!word_divides(LANES, PIX_OUT_W, OUT_W, DUP)) begin : g_bad_out_w
        $error("OUT_W must be a multiple of the packed beat width");
    end

    logic [BB-1:0]    beat;
    logic [PIX_OUT_W-1:0] pix_byte;
    logic [OUT_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BCW-1:0]   cnt_next;
    logic             push_req_q, push_req_d;
    logic             ovf_q;
    logic             fifo_drop;
    logic [CW-1:0]    count_w;
    int               pad_bits;

    // The low-order bits of every lane are discarded by design.
    logic             pix_lsb_unused;
    assign pix_lsb_unused = ^pix_data;

    // Lane extraction: keep the MSBs of each lane, highest lane most significant.
    always_comb begin
        beat     = '0;
        pix_byte = '0;
        for (int l = 0; l < LANES; l++) begin
            pix_byte = pix_data[l*PIX_IN_W + PIX_IN_W-1 -: PIX_OUT_W];
`ifdef PACK_DUP_EN
            beat[l*LB +: LB] = {pix_byte, pix_byte};
`else
            beat[l*LB +: LB] = pix_byte;
`endif
        end
    end

    // Beat accumulation, word completion and frame-end zero-pad flush.
    always_comb begin
        shreg_d    = shreg_q;
        beat_cnt_d = beat_cnt_q;
        push_req_d = 1'b0;
        cnt_next   = beat_cnt_q;
        pad_bits   = 0;
        if (frame_start) begin
            // Resync wins over everything: drop the partial word, keep the FIFO.
            shreg_d    = '0;
            beat_cnt_d = '0;
        end else begin
            if (pix_vld) begin
                shreg_d  = (shreg_q << BB) | OUT_W'(beat);
                cnt_next = beat_cnt_q + 1'b1;
            end
            if (cnt_next == BCW'(BEATS)) begin
                // Full word, whether or not frame_end arrived with the last beat.
                push_req_d = 1'b1;
                beat_cnt_d = '0;
            end else if (frame_end && (cnt_next != '0)) begin
                // Left-align the partial word so the empty slots read as zero.
                pad_bits   = (BEATS - int'(cnt_next)) * BB;
                shreg_d    = shreg_d << pad_bits;
                push_req_d = 1'b1;
                beat_cnt_d = '0;
            end else if (frame_end) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = cnt_next;
            end
        end
    end

    // Packer state; the completed word stays in shreg_q for the push cycle.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            shreg_q    <= '0;
            beat_cnt_q <= '0;
            push_req_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            beat_cnt_q <= beat_cnt_d;
            push_req_q <= push_req_d;
        end
    end

    // Sticky overflow: a same-cycle drop beats the clear.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            ovf_q <= 1'b0;
        end else if (fifo_drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    pp_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk     (sclk),
        .rst     (s_rst),
        .wr_en   (push_req_q),
        .wr_data (shreg_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count_w),
        .drop    (fifo_drop)
    );

    assign data_count = count_w;
    assign wr_trig    = (count_w >= CW'(BURST_LEN));
    assign ovf        = ovf_q;

endmodule
